// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC increment and the queue slot record for the fetch front end
package fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              filled;
    } slot_t;
endpackage

// File: rtl/fetch_slot_array.sv
// fetch_slot_array: circular buffer of fetch slots with alloc/fill/pop/flush and occupancy tracking
module fetch_slot_array
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [ADDR_W-1:0]        alloc_pc,
    input  logic                     fill,
    input  logic [INST_W-1:0]        fill_inst,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pend,
    output slot_t                    head_slot
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    slot_t slots [DEPTH];
    logic [PW-1:0] head, tail, fill_ptr;
    assign head_slot = slots[head];
    // a pop after a fill of the same slot wins, so a bypassed word leaves no stored copy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
        end else begin
            if (alloc) begin
                slots[tail] <= '{pc: alloc_pc, inst: '0, filled: 1'b0};
                tail        <= tail + PW'(1);
            end
            if (fill) begin
                slots[fill_ptr].inst   <= fill_inst;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + PW'(1);
            end
            if (pop) begin
                slots[head] <= '0;
                head        <= head + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
            pend  <= pend + CW'(alloc) - CW'(fill);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, memory request issue, wrong-path discard and decode handoff (optional FETCHQ_BYPASS_EN)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc_4,
    input  logic              out_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0] count, pend, discard_cnt;
    slot_t head_slot;
    logic grant, fill, pop, byp;
    // issue, response steering and decode-side outputs; redirect masks both request and output
    always_comb begin
        mem_req  = rst & (count < CW'(DEPTH)) & ~redirect;
        mem_addr = fetch_pc;
        grant    = mem_req & mem_gnt;
        fill     = mem_rvalid & (discard_cnt == '0);
`ifdef FETCHQ_BYPASS_EN
        byp       = fill & (count != '0) & ~head_slot.filled;
        out_valid = ~redirect & (head_slot.filled | byp);
        out_inst  = ~out_valid ? '0 : head_slot.filled ? head_slot.inst : mem_rdata;
`else
        byp       = 1'b0;
        out_valid = ~redirect & head_slot.filled;
        out_inst  = out_valid ? head_slot.inst : '0;
`endif
        out_pc_4 = out_valid ? head_slot.pc + PC_STEP : '0;
        pop      = out_valid & out_ready;
    end
    // fetch PC advance and count of responses still owed to flushed requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            discard_cnt <= discard_cnt + pend - CW'(mem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + PC_STEP;
            if (mem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        end
    end
    fetch_slot_array #(.DEPTH(DEPTH)) u_slots (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .alloc     (grant),
        .alloc_pc  (fetch_pc),
        .fill      (fill),
        .fill_inst (mem_rdata),
        .pop       (pop),
        .count     (count),
        .pend      (pend),
        .head_slot (head_slot)
    );
    logic unused_byp;
    assign unused_byp = byp;
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues in-order read requests to instruction memory over a grant/valid interface that may stall, buffers up to DEPTH fetched instructions with their PC+4, and hands them to decode with a valid/ready handshake. A redirect input, driven by branch, jump or jr resolution, flushes all buffered and in-flight wrong-path fetches.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also caps outstanding memory requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; word-aligned.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch address; equals fetch_pc.
- mem_gnt  in  1  request accepted when mem_req & mem_gnt.
- mem_rvalid  in  1  read data valid; one pulse per granted request, in order, ≥1 cycle after grant.
- mem_rdata  in  32  instruction word.
- out_valid  out  1  instruction available to decode.
- out_inst  out  32  instruction; 0 when out_valid=0.
- out_pc_4  out  32  PC of out_inst plus 4; 0 when out_valid=0.
- out_ready  in  1  decode accepts; transfer when out_valid & out_ready.

## Operation
- State: fetch_pc; circular slot array of DEPTH entries {pc, inst, filled}; head, tail and fill pointers, each log2(DEPTH) bits, wrapping modulo DEPTH; count in 0..DEPTH; discard_cnt in 0..DEPTH.
- Issue: mem_req = (count < DEPTH) & ~redirect. On grant: allocate slot at tail with pc=fetch_pc, filled=0; tail+1; count+1; fetch_pc += 4, modulo 2^32.
- Response: if discard_cnt > 0, drop mem_rdata and decrement discard_cnt. Otherwise write inst into the slot at fill, set filled, fill+1.
- Output: out_valid = head slot filled & ~redirect. On transfer, clear the slot, head+1, count−1.
- Redirect has priority over issue and pop. All slots are cleared; head=tail=fill=0; count=0; fetch_pc <= redirect_pc. discard_cnt <= discard_cnt + (allocated-unfilled slots) − (1 if this cycle's rvalid is itself dropped or filled, net of that response).
  - The resulting discard_cnt equals the exact number of responses still owed for pre-redirect grants.
- Full: count is sampled from current state. A slot freed by a pop this cycle is reusable only next cycle.
- Back-to-back redirects: each one recomputes discard_cnt. fetch_pc takes the latest redirect_pc.
- Reset mid-operation: everything returns to reset state immediately. The memory side must also be reset; in-flight responses are not tracked across reset.

## Timing
- Reset values:
  - mem_req=0 while rst low, 1 from the first cycle after release.
  - mem_addr=RESET_PC; out_valid=0; out_inst=0; out_pc_4=0; discard_cnt=0.
- Latency: grant at cycle t, rvalid at t+L, out_valid at t+L+1 (slot written at the edge).
- Throughput: one instruction per cycle sustained when L ≤ DEPTH−1 and both gnt and ready stay high.
- mem_addr is stable while mem_req=1 and mem_gnt=0.
- The cycle after a redirect, mem_req=1 with mem_addr=redirect_pc.

## Configuration
- FETCHQ_BYPASS_EN defined: when count slots are all empty except the head slot being filled this cycle, and discard_cnt=0, out_valid asserts in the same cycle as mem_rvalid, with out_inst=mem_rdata. Latency becomes t+L. If out_ready is high, the slot is consumed without a stored copy.
- Undefined: no combinational path from mem_rvalid or mem_rdata to outputs; latency is t+L+1.

## Structure
- Shared package fetch_pkg: ADDR_W=32, INST_W=32, PC_STEP=4, and the slot struct type {pc, inst, filled}.
- One sub-module, fetch_slot_array: DEPTH slots with alloc, fill, pop and flush ports, plus pointer and count logic.
- fetch_queue keeps fetch_pc, issue logic, discard_cnt and bypass.

## Test plan
- Reset release; gnt=1, rvalid one cycle after grant, out_ready=1 → mem_addr 0,4,8,…; out_pc_4 4,8,12 on consecutive cycles from cycle 3; no gaps.
- out_ready=0 with DEPTH=4 → exactly 4 grants, then mem_req=0. Raise out_ready → instructions emerge in order, issue resumes at address 16.
- mem_gnt low for 3 cycles → mem_addr held at 8 throughout; no slot allocated.
- 3 requests outstanding, redirect with redirect_pc=0x40 → next mem_addr=0x40. The next 3 rvalid words (0xDEAD0001..3) are dropped; the first out_inst is the word fetched at 0x40, with out_pc_4=0x44.
- Redirect in the same cycle as an rvalid and a ready head slot → out_valid=0 that cycle, nothing consumed, and discard_cnt accounts the concurrent response.
- Pull rst low with 2 slots filled → outputs zero immediately. After release, mem_addr=RESET_PC.
